// File: rtl/ping_pong_line_ctrl.sv
// ping_pong_line_ctrl
// Sequencer for a 2-bank ping-pong line RAM. Line N is written from a
// valid/ready pixel stream while line N-1 is read back and streamed out
// through a 2-entry skid FIFO. ram_line_end swaps the banks between lines.
// Optional build macro: PPLC_LEN_CHECK_EN (sticky line-length mismatch flag).
module ping_pong_line_ctrl #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 8,
    parameter int MAX_LINE = 2048
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_frame_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_write_addr,
    output logic [DATA_W-1:0] ram_write_data,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_read_addr,
    input  logic [DATA_W-1:0] ram_read_data,
    output logic              ram_line_end,
    output logic              overflow,
    output logic              len_err
);

    localparam int LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(MAX_LINE - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SWAP  = 3'd3,
        ST_RUN   = 3'd4,
        ST_DRAIN = 3'd5
    } state_t;

    state_t            state_r, next_state_s;
    logic              in_ready_r, line_end_r, wait_seen_r;
    logic              ready_next_s, line_end_next_s, rd_state_s;

    logic [LEN_W-1:0]  wr_cnt_r, next_len_r, new_len_s;
    logic              line_ovf_r, frame_last_r, overflow_r;
    logic              accept_s, last_acc_s;

    logic [LEN_W-1:0]  rd_len_r, rd_cnt_r;
    logic              inflight_r, inflight_last_r;
    logic              re_s, pop_s, rd_done_s, last_pop_s;
    logic [2:0]        occ_s;

    logic [DATA_W-1:0] fifo_data_r [2];
    logic [1:0]        fifo_last_r;
    logic              fifo_wp_r, fifo_rp_r;
    logic [1:0]        fifo_cnt_r;

    assign accept_s   = in_valid & in_ready_r;
    assign last_acc_s = accept_s & in_last;
    // The counter holds at LAST_IDX on an overlong line, so this saturates at MAX_LINE.
    assign new_len_s  = wr_cnt_r + LEN_W'(1);

    assign pop_s      = (fifo_cnt_r != 2'd0) & out_ready;
    // Occupancy seen by the next cycle: a pop this cycle frees a slot, which keeps 1 pixel/cycle.
    assign occ_s      = {1'b0, fifo_cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign re_s       = rd_state_s & (rd_cnt_r < rd_len_r) & (occ_s < 3'd2);
    assign rd_done_s  = (rd_cnt_r == rd_len_r) & ~inflight_r & (fifo_cnt_r == 2'd0);
    assign last_pop_s = (rd_cnt_r == rd_len_r) & ~inflight_r & pop_s & (fifo_cnt_r == 2'd1);

    // State register plus the registered handshake/swap outputs derived from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            line_end_r  <= 1'b0;
            wait_seen_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            in_ready_r  <= ready_next_s;
            line_end_r  <= line_end_next_s;
            wait_seen_r <= (state_r == ST_WAIT);
        end
    end

    // Next-state logic; WAIT holds at least two cycles so the RAM's delayed write lands first.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (last_acc_s)    next_state_s = ST_WAIT;
                else if (accept_s) next_state_s = ST_FILL;
                else               next_state_s = ST_IDLE;
            end
            ST_FILL, ST_RUN: begin
                if (last_acc_s) next_state_s = ST_WAIT;
                else            next_state_s = state_r;
            end
            ST_WAIT: begin
                if (wait_seen_r && rd_done_s) next_state_s = ST_SWAP;
                else                          next_state_s = ST_WAIT;
            end
            ST_SWAP: begin
                if (frame_last_r) next_state_s = ST_DRAIN;
                else              next_state_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (last_pop_s || rd_done_s) next_state_s = ST_IDLE;
                else                         next_state_s = ST_DRAIN;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output decode: reading continues through WAIT so the previous line can finish.
    always_comb begin
        rd_state_s      = (state_r == ST_RUN) | (state_r == ST_WAIT) | (state_r == ST_DRAIN);
        ready_next_s    = (next_state_s == ST_IDLE) | (next_state_s == ST_FILL) |
                          (next_state_s == ST_RUN);
        line_end_next_s = (next_state_s == ST_SWAP);
    end

    // Write side: address counter, overflow suppression and captured line length.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt_r     <= {LEN_W{1'b0}};
            next_len_r   <= {LEN_W{1'b0}};
            line_ovf_r   <= 1'b0;
            frame_last_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else if (last_acc_s) begin
            next_len_r   <= new_len_s;
            frame_last_r <= in_frame_last;
            wr_cnt_r     <= {LEN_W{1'b0}};
            line_ovf_r   <= 1'b0;
        end else if (accept_s) begin
            if (wr_cnt_r == LAST_IDX) begin
                line_ovf_r <= 1'b1;
                overflow_r <= 1'b1;
            end else begin
                wr_cnt_r <= wr_cnt_r + LEN_W'(1);
            end
        end
    end

    // Read side: length is taken over at the bank swap, then one address per ram_re.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_len_r        <= {LEN_W{1'b0}};
            rd_cnt_r        <= {LEN_W{1'b0}};
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
        end else begin
            if (state_r == ST_SWAP) begin
                rd_len_r <= next_len_r;
                rd_cnt_r <= {LEN_W{1'b0}};
            end else if (re_s) begin
                rd_cnt_r <= rd_cnt_r + LEN_W'(1);
            end
            inflight_r      <= re_s;
            inflight_last_r <= re_s & (rd_cnt_r == (rd_len_r - LEN_W'(1)));
        end
    end

    // Skid FIFO: captures read data one cycle after ram_re, flushed by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_data_r[0] <= {DATA_W{1'b0}};
            fifo_data_r[1] <= {DATA_W{1'b0}};
            fifo_last_r    <= 2'b00;
            fifo_wp_r      <= 1'b0;
            fifo_rp_r      <= 1'b0;
            fifo_cnt_r     <= 2'd0;
        end else begin
            if (inflight_r) begin
                fifo_data_r[fifo_wp_r] <= ram_read_data;
                fifo_last_r[fifo_wp_r] <= inflight_last_r;
                fifo_wp_r              <= ~fifo_wp_r;
            end
            if (pop_s) begin
                fifo_rp_r <= ~fifo_rp_r;
            end
            if (inflight_r && !pop_s) begin
                fifo_cnt_r <= fifo_cnt_r + 2'd1;
            end else if (pop_s && !inflight_r) begin
                fifo_cnt_r <= fifo_cnt_r - 2'd1;
            end
        end
    end

`ifdef PPLC_LEN_CHECK_EN
    logic have_prev_r, len_err_r;

    // Length consistency: every completed line after the first is compared with its predecessor.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            have_prev_r <= 1'b0;
            len_err_r   <= 1'b0;
        end else if (last_acc_s) begin
            have_prev_r <= 1'b1;
            if (have_prev_r && (new_len_s != next_len_r)) begin
                len_err_r <= 1'b1;
            end
        end
    end

    assign len_err = len_err_r;
`else
    assign len_err = 1'b0;
`endif

    assign in_ready       = in_ready_r;
    assign ram_line_end   = line_end_r;
    assign overflow       = overflow_r;
    assign ram_we         = accept_s & ~line_ovf_r;
    assign ram_write_addr = wr_cnt_r[ADDR_W-1:0];
    assign ram_write_data = ram_we ? in_data : {DATA_W{1'b0}};
    assign ram_re         = re_s;
    assign ram_read_addr  = rd_cnt_r[ADDR_W-1:0];
    assign out_valid      = (fifo_cnt_r != 2'd0);
    assign out_data       = out_valid ? fifo_data_r[fifo_rp_r] : {DATA_W{1'b0}};
    assign out_last       = out_valid & fifo_last_r[fifo_rp_r];

endmodule

// File: tb/tb_ping_pong_line_ctrl.sv
// Self-checking bench for ping_pong_line_ctrl: a 2-bank RAM with a delayed
// write, a pixel scoreboard (queue of expected output pixels per line) and
// randomized line lengths, input gaps and output back-pressure.
module tb_ping_pong_line_ctrl;

    localparam int ADDR_W   = 11;
    localparam int DATA_W   = 8;
    localparam int MAX_LINE = 2048;
    localparam int TMO      = 20000;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid, in_ready, in_last, in_frame_last;
    logic [DATA_W-1:0] in_data;
    logic              out_valid, out_ready, out_last;
    logic [DATA_W-1:0] out_data;
    logic              ram_we, ram_re, ram_line_end, overflow, len_err;
    logic [ADDR_W-1:0] ram_write_addr, ram_read_addr;
    logic [DATA_W-1:0] ram_write_data, ram_read_data;
    logic [45:0]       all_outs;

    ping_pong_line_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LINE(MAX_LINE)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_frame_last(in_frame_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .ram_we(ram_we), .ram_write_addr(ram_write_addr), .ram_write_data(ram_write_data),
        .ram_re(ram_re), .ram_read_addr(ram_read_addr), .ram_read_data(ram_read_data),
        .ram_line_end(ram_line_end), .overflow(overflow), .len_err(len_err)
    );

    assign all_outs = {in_ready, out_valid, out_last, out_data, ram_we, ram_re, ram_line_end,
                       ram_write_data, overflow, len_err, ram_write_addr, ram_read_addr};

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- RAM model: two banks, write lands one cycle late ----------------
    logic [DATA_W-1:0] mem [0:1][0:MAX_LINE-1];
    logic              wbank, pend_v;
    logic [ADDR_W-1:0] pend_a;
    logic [DATA_W-1:0] pend_d;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wbank <= 1'b0; pend_v <= 1'b0; pend_a <= '0; pend_d <= '0; ram_read_data <= '0;
        end else begin
            if (pend_v) mem[wbank][pend_a] <= pend_d;
            pend_v <= ram_we; pend_a <= ram_write_addr; pend_d <= ram_write_data;
            if (ram_re) ram_read_data <= mem[wbank ^ 1'b1][ram_read_addr];
            if (ram_line_end) wbank <= ~wbank;
        end
    end

    // ---------------- scoreboard / reference model ----------------
    logic [8:0] exp_q [$];
    int line_pos, we_line_cnt, le_cnt, exp_le, prev_len, occ, max_occ, cyc, last_we_cyc;
    bit have_prev, exp_len_err, exp_ovf, re_prev;
    int rdy_mode;

    task automatic reset_model();
        exp_q.delete();
        line_pos = 0; we_line_cnt = 0; le_cnt = 0; exp_le = 0; prev_len = 0;
        occ = 0; max_occ = 0; last_we_cyc = -100;
        have_prev = 1'b0; exp_len_err = 1'b0; exp_ovf = 1'b0; re_prev = 1'b0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [8:0] e;
        int len_eff;
        if (reset_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("out_unexpected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("out_data", out_data, e[7:0]);
                    check_eq("out_last", out_last, e[8]);
                end
            end
            if (ram_we) begin
                check_eq("waddr", ram_write_addr, we_line_cnt);
                check_eq("wdata", ram_write_data, in_data);
                we_line_cnt++;
                last_we_cyc = cyc;
            end
            if (ram_line_end) begin
                le_cnt++;
                check_eq("le_gap_ge2", (cyc - last_we_cyc) >= 2, 1);
                check_eq("le_read_inflight", re_prev, 0);
            end
            if (in_valid && in_ready) begin
                if (line_pos < MAX_LINE) exp_q.push_back({1'b0, in_data});
                line_pos++;
                if (in_last) begin
                    e = exp_q[exp_q.size()-1];
                    e[8] = 1'b1;
                    exp_q[exp_q.size()-1] = e;
                    len_eff = (line_pos > MAX_LINE) ? MAX_LINE : line_pos;
                    if (line_pos > MAX_LINE) exp_ovf = 1'b1;
                    check_eq("we_per_line", we_line_cnt, len_eff);
`ifdef PPLC_LEN_CHECK_EN
                    if (have_prev && (len_eff != prev_len)) exp_len_err = 1'b1;
`endif
                    prev_len = len_eff; have_prev = 1'b1;
                    exp_le++;
                    line_pos = 0; we_line_cnt = 0;
                end
            end
            occ = occ + (ram_re ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
            if (occ > max_occ) max_occ = occ;
            re_prev = ram_re;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                2:       out_ready = 1'($urandom_range(1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic send_line(input int len, input bit fl, input int gap_pct, input bit do_last,
                             input int base);
        bit accepted;
        int n;
        for (int i = 0; i < len; i++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid      = 1'b1;
            in_data       = (base >= 0) ? 8'(base + i) : 8'($urandom);
            in_last       = do_last && (i == len - 1);
            in_frame_last = (i == len - 1) ? fl : 1'($urandom_range(1));
            accepted = 1'b0; n = 0;
            while (!accepted && n < TMO) begin
                @(negedge clk);
                if (in_ready) accepted = 1'b1; else n++;
            end
            if (!accepted) check_eq("accept_timeout", accepted, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0; in_frame_last = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < TMO) begin
            @(negedge clk); n++;
        end
        check_eq("drain_queue_empty", exp_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
        check_eq("line_end_count", le_cnt, exp_le);
        check_eq("len_err", len_err, exp_len_err);
        check_eq("overflow", overflow, exp_ovf);
        check_eq("fifo_occ_le2", max_occ <= 2, 1);
        check_eq("idle_in_ready", in_ready, 1);
        check_eq("idle_out_valid", out_valid, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0; reset_n = 1'b0; rdy_mode = 0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_frame_last = 1'b0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", all_outs, 0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        check_eq("idle_in_ready_after_reset", in_ready, 1);

        // Two 16-pixel lines with sequential data, full-speed output.
        rdy_mode = 0;
        send_line(16, 1'b0, 0, 1'b1, 0);
        send_line(16, 1'b1, 0, 1'b1, 16);
        wait_drain();

        // Length change 16 -> 15.
        send_line(16, 1'b0, 0, 1'b1, -1);
        send_line(15, 1'b1, 0, 1'b1, -1);
        wait_drain();
`ifdef PPLC_LEN_CHECK_EN
        check_eq("len_err_set", len_err, 1);
`else
        check_eq("len_err_tied", len_err, 0);
`endif

        // Toggling back-pressure.
        rdy_mode = 1;
        send_line(20, 1'b0, 0, 1'b1, -1);
        send_line(20, 1'b0, 0, 1'b1, -1);
        send_line(20, 1'b1, 0, 1'b1, -1);
        wait_drain();

        // Short writer line behind a long stalled reader line.
        rdy_mode = 3;
        send_line(64, 1'b0, 0, 1'b1, -1);
        send_line(4, 1'b1, 0, 1'b1, -1);
        repeat (20) @(negedge clk);
        check_eq("stall_in_ready", in_ready, 0);
        check_eq("stall_out_valid", out_valid, 1);
        rdy_mode = 0;
        wait_drain();

        // Single-pixel lines.
        rdy_mode = 2;
        send_line(1, 1'b0, 0, 1'b1, -1);
        send_line(1, 1'b0, 0, 1'b1, -1);
        send_line(1, 1'b1, 0, 1'b1, -1);
        wait_drain();

        // Random frames.
        for (int f = 0; f < 6; f++) begin
            int nl;
            nl = int'($urandom_range(1, 4));
            for (int l = 0; l < nl; l++) begin
                send_line(int'($urandom_range(1, 40)), (l == nl - 1), 30, 1'b1, -1);
            end
            wait_drain();
        end

        // Overlong line: 2050 pixels.
        rdy_mode = 0;
        send_line(2050, 1'b1, 0, 1'b1, -1);
        wait_drain();
        check_eq("overflow_set", overflow, 1);

        // Reset in the middle of RUN, then a fresh 8-pixel frame.
        send_line(16, 1'b0, 0, 1'b1, -1);
        send_line(8, 1'b0, 0, 1'b0, -1);
        #2;
        in_valid = 1'b1; in_data = 8'hA5;
        reset_n = 1'b0;
        #1;
        check_eq("midrun_reset_outputs", all_outs, 0);
        reset_model();
        repeat (2) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        send_line(8, 1'b1, 0, 1'b1, 100 - 100);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
